mem_port_arbiter: RTL and testbench

- Sequences the single shared data-memory port of the NPC core and arbitrates it between two requesters: instruction fetch (IFU) and load/store (LSU).
- Each accepted request becomes one registered memory transaction: request handshake, then wait for the response, then a response pulse back to the owning requester.
- Replaces the combinational, every-evaluation memory access in the single-cycle top with a clocked, one-outstanding-transaction controller.
- Includes a response timeout so that a hung memory model cannot stall the core silently.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared data-memory port (IFU vs LSU).
// One transaction outstanding: grant in IDLE, request handshake, response wait with timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp_err,
    output logic              busy,
    output logic              timeout_seen
);
    // state  | meaning
    // S_IDLE | no transaction; grant a requester (round-robin on ties)
    // S_REQ  | mem_req_valid high from latched fields until mem_req_ready
    // S_WAIT | waiting for mem_resp_valid, counting toward TIMEOUT
    // S_RESP | one-cycle response pulse to the owning requester

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              owner_lsu_q;
    logic              last_lsu_q;
    logic              timeout_seen_q;
    logic              grant_ifu, grant_lsu;
    logic              timeout_hit;

    // Reset gates the grant so no ready is shown while the block is held in reset.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst && (state_q == S_IDLE)) begin
            grant_ifu = ifu_req_valid && (!lsu_req_valid || last_lsu_q);
            grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: if (grant_ifu || grant_lsu) state_d = S_REQ;
            S_REQ:  if (mem_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_RESP;
                    timeout_hit = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q          <= '0;
            addr_q         <= '0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            owner_lsu_q    <= 1'b0;
            last_lsu_q     <= 1'b1;
            timeout_seen_q <= 1'b0;
        end else begin
            if (grant_ifu) begin
                addr_q      <= ifu_addr;
                wen_q       <= 1'b0;
                wdata_q     <= '0;
                wmask_q     <= '0;
                owner_lsu_q <= 1'b0;
                last_lsu_q  <= 1'b0;
            end else if (grant_lsu) begin
                addr_q      <= lsu_addr;
                wen_q       <= lsu_wen;
                wdata_q     <= lsu_wdata;
                wmask_q     <= lsu_wmask;
                owner_lsu_q <= 1'b1;
                last_lsu_q  <= 1'b1;
            end
            if ((state_q == S_REQ) && mem_req_ready) cnt_q <= '0;
            if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (mem_resp_valid) begin
                    rdata_q <= wen_q ? '0 : mem_rdata;
                    err_q   <= mem_resp_err;
                end else if (timeout_hit) begin
                    rdata_q        <= '0;
                    err_q          <= 1'b1;
                    timeout_seen_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ifu_req_ready  = grant_ifu;
        lsu_req_ready  = grant_lsu;
        mem_req_valid  = (state_q == S_REQ);
        mem_addr       = addr_q;
        mem_wen        = wen_q;
        mem_wdata      = wdata_q;
        mem_wmask      = wmask_q;
        ifu_resp_valid = (state_q == S_RESP) && !owner_lsu_q;
        lsu_resp_valid = (state_q == S_RESP) && owner_lsu_q;
        ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
        ifu_err        = ifu_resp_valid && err_q;
        lsu_rdata      = lsu_resp_valid ? rdata_q : '0;
        lsu_err        = lsu_resp_valid && err_q;
        busy           = (state_q != S_IDLE);
        timeout_seen   = timeout_seen_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and randomized transactions against a
// transaction-level model (round-robin owner, expected wait length, response data).
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic        clk, rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy, timeout_seen;

    int compared   = 0;
    int mismatched = 0;
    bit m_last_lsu = 1'b1;
    bit m_to_seen  = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .busy(busy), .timeout_seen(timeout_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full transaction; returns at the IDLE cycle that follows the response pulse.
    task automatic run_txn(input logic iv, input logic lv, input logic [31:0] ia,
                           input logic [31:0] la, input logic lw, input logic [31:0] lwd,
                           input logic [7:0] lm, input int rdy_dly, input int rsp_dly,
                           input logic [31:0] rd, input logic merr);
        logic        g_lsu, to_exp, e_wen, e_err;
        logic [31:0] e_addr, e_rd;
        logic [7:0]  e_mask;
        int          n_wait;
        g_lsu      = (iv && lv) ? !m_last_lsu : lv;
        m_last_lsu = g_lsu;
        e_addr     = g_lsu ? la : ia;
        e_wen      = g_lsu ? lw : 1'b0;
        e_mask     = g_lsu ? lm : 8'h00;
        to_exp     = (rsp_dly >= TO);
        n_wait     = to_exp ? TO : rsp_dly + 1;
        e_rd       = (to_exp || e_wen) ? 32'h0 : rd;
        e_err      = to_exp ? 1'b1 : merr;

        ifu_req_valid = iv; ifu_addr = ia;
        lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lm;
        #1;
        compared++;
        if ({ifu_req_ready, lsu_req_ready} !== {!g_lsu, g_lsu}) begin
            mismatched++;
            $display("FAIL grant: ifu/lsu ready=%b%b required=%b%b",
                     ifu_req_ready, lsu_req_ready, !g_lsu, g_lsu);
        end
        @(posedge clk); @(negedge clk);
        if (g_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;

        for (int k = 0; k <= rdy_dly; k++) begin
            mem_req_ready  = (k == rdy_dly);
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_err   = 1'($urandom_range(0, 1));
            mem_rdata      = $urandom;
            #1;
            compared++;
            if ({mem_req_valid, ifu_req_ready, lsu_req_ready, busy, mem_addr, mem_wen, mem_wmask}
                !== {1'b1, 1'b0, 1'b0, 1'b1, e_addr, e_wen, e_mask}) begin
                mismatched++;
                $display("FAIL req_phase cycle %0d: vld=%b rdy=%b%b busy=%b addr=%h wen=%b mask=%h required addr=%h wen=%b mask=%h",
                         k, mem_req_valid, ifu_req_ready, lsu_req_ready, busy, mem_addr,
                         mem_wen, mem_wmask, e_addr, e_wen, e_mask);
            end
            if (g_lsu) begin
                compared++;
                if (mem_wdata !== lwd) begin
                    mismatched++;
                    $display("FAIL req_wdata: mem_wdata=%h required=%h", mem_wdata, lwd);
                end
            end
            @(posedge clk); @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        for (int w = 0; w < n_wait; w++) begin
            mem_resp_valid = (w == rsp_dly);
            mem_rdata      = rd;
            mem_resp_err   = merr;
            #1;
            compared++;
            if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, busy} !== 4'b0001) begin
                mismatched++;
                $display("FAIL wait_phase cycle %0d: req_vld=%b resp=%b%b busy=%b required 0,00,1",
                         w, mem_req_valid, ifu_resp_valid, lsu_resp_valid, busy);
            end
            @(posedge clk); @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        if (to_exp) m_to_seen = 1'b1;

        #1;
        compared++;
        if ({ifu_resp_valid, ifu_rdata, ifu_err, lsu_resp_valid, lsu_rdata, lsu_err} !==
            (g_lsu ? {1'b0, 32'h0, 1'b0, 1'b1, e_rd, e_err}
                   : {1'b1, e_rd, e_err, 1'b0, 32'h0, 1'b0})) begin
            mismatched++;
            $display("FAIL resp: ifu v/d/e=%b/%h/%b lsu v/d/e=%b/%h/%b required owner_lsu=%b data=%h err=%b",
                     ifu_resp_valid, ifu_rdata, ifu_err, lsu_resp_valid, lsu_rdata, lsu_err,
                     g_lsu, e_rd, e_err);
        end
        compared++;
        if ({busy, ifu_req_ready, lsu_req_ready, timeout_seen} !== {1'b1, 1'b0, 1'b0, m_to_seen}) begin
            mismatched++;
            $display("FAIL resp_ctrl: busy=%b rdy=%b%b timeout_seen=%b required 1,00,%b",
                     busy, ifu_req_ready, lsu_req_ready, timeout_seen, m_to_seen);
        end
        @(posedge clk); @(negedge clk);
        #1;
        compared++;
        if ({busy, ifu_resp_valid, lsu_resp_valid, mem_req_valid, timeout_seen} !==
            {4'b0000, m_to_seen}) begin
            mismatched++;
            $display("FAIL idle_after: busy=%b resp=%b%b req_vld=%b timeout_seen=%b required 0,00,0,%b",
                     busy, ifu_resp_valid, lsu_resp_valid, mem_req_valid, timeout_seen, m_to_seen);
        end
    endtask

    task automatic check_all_zero(input string tag);
        compared++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err, lsu_resp_valid,
             lsu_rdata, lsu_err, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
             busy, timeout_seen} !== 148'h0) begin
            mismatched++;
            $display("FAIL %s: outputs=%h required all zero", tag,
                     {ifu_req_ready, lsu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
                      lsu_resp_valid, lsu_rdata, lsu_err, mem_req_valid, mem_addr, mem_wen,
                      mem_wdata, mem_wmask, busy, timeout_seen});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h1234_5678;
        lsu_req_valid = 1'b1; lsu_addr = 32'h9abc_def0; lsu_wen = 1'b1;
        lsu_wdata = 32'hffff_ffff; lsu_wmask = 8'hff;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hffff_ffff; mem_resp_err = 1'b1;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        check_all_zero("idle_no_request");
    endtask

    task automatic test_ifu_read();
        run_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 8'h00, 0, 0, 32'h0010_0073, 1'b0);
    endtask

    task automatic test_lsu_store();
        run_txn(1'b0, 1'b1, 32'h0, 32'h8000_1004, 1'b1, 32'hdead_beef, 8'h0f, 0, 0,
                32'h1234_5678, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0, 32'h8000_2000, 1'b0, 32'h0, 8'h00, 1, 2, 32'hcafe_f00d, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_txn(1'b1, 1'b1, 32'h8000_0000 + 32'(4 * i), 32'h9000_0000 + 32'(4 * i),
                    1'(i % 2), $urandom, 8'($urandom), 0, 0, $urandom, 1'b0);
    endtask

    task automatic test_stall();
        run_txn(1'b0, 1'b1, 32'h0, 32'h8000_0040, 1'b1, 32'h5555_aaaa, 8'h3c, 5, 1, 32'h0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h8000_0080, 32'h0, 1'b0, 32'h0, 8'h00, 5, 0, 32'h0badc0de, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 32'h8000_0100, 32'h0, 1'b0, 32'h0, 8'h00, 0, 100, 32'h1111_1111, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0, 32'h8000_0104, 1'b0, 32'h0, 8'h00, 0, TO - 1, 32'h2222_2222, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0, 32'h8000_0108, 1'b1, 32'h3, 8'h01, 2, TO, 32'h3333_3333, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic iv, lv;
            iv = 1'($urandom_range(0, 1));
            lv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(iv, lv, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                    8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                    $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_wait();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200; lsu_req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_req_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_wait_busy: busy=%b required 1", busy);
        end
        #1 rst = 1'b0;
        #1;
        check_all_zero("async_reset_in_wait");
        m_last_lsu = 1'b1;
        m_to_seen  = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'hfeed_face;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if ({busy, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
                mismatched++;
                $display("FAIL post_reset_no_resp cycle %0d: busy=%b resp=%b%b required 0,00",
                         i, busy, ifu_resp_valid, lsu_resp_valid);
            end
            @(posedge clk); @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        run_txn(1'b1, 1'b1, 32'h8000_0300, 32'h8000_0304, 1'b0, 32'h0, 8'h00, 0, 0,
                32'h0000_0013, 1'b0);
        run_txn(1'b1, 1'b1, 32'h8000_0308, 32'h8000_030c, 1'b0, 32'h0, 8'h00, 0, 1,
                32'h0000_0093, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_store();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_random();
        test_reset_mid_wait();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
